mux_v_n_pack: RTL and testbench

TX-side packer for the v/n symbol stream. It accepts 6-bit v-symbols or 4-bit n-symbols through a valid/ready handshake and packs them LSB-first into RAM_W-bit words. Each completed word is written to the TX block RAM through a simple write port. At end of frame it reports the last written word index in the `weight_pack` format that the RX-side unpacker consumes.

---
 rtl/mux_v_n_pack.sv | 150 +++++++++++++++
 tb/tb_mux_v_n_pack.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_v_n_pack.sv
// mux_v_n_pack: TX-side packer for the v/n symbol stream.
// v-mode packs five 6-bit symbols per word, n-mode eight 4-bit symbols,
// LSB-first. Completed words go out on a registered single-port write
// strobe; the index of the last word of a frame is reported on weight_pack.
// Optional build macro: MUX_PACK_MARK_EN stamps v-mode words with a
// final-word flag in bit31 and even parity over [29:0] in bit30.
module mux_v_n_pack #(
    parameter int RAM_W  = 32,
    parameter int ADDR_W = 10,
    parameter int V_W    = 6,
    parameter int N_W    = 4
) (
    input  logic              clk_15_o,
    input  logic              nrst,
    input  logic              cod_ce_v,
    input  logic              cod_ce_n,
    input  logic              sym_valid,
    input  logic [V_W-1:0]    sym_data,
    input  logic              sym_last,
    output logic              sym_ready,
    output logic              ram_tx_we,
    output logic [ADDR_W-1:0] ram_tx_addr,
    output logic [RAM_W-1:0]  ram_tx_data,
    output logic [ADDR_W-1:0] weight_pack,
    output logic              frame_done,
    output logic              ovf
);
    typedef enum logic [1:0] {IDLE, PACK, LAST, DONE} state_t;

    localparam int V_SLOTS = 5;
    localparam int N_SLOTS = 8;

    state_t            state, state_nxt;
    logic              mode_n_q;
    logic              full_q;     // word at the top index already written
    logic [2:0]        slot_q;
    logic [ADDR_W-1:0] idx_q;
    logic [RAM_W-1:0]  asm_q;

    logic              accept, in_idle, mode_n, word_full;
    logic [2:0]        slot;
    logic [ADDR_W-1:0] idx;
    logic [RAM_W-1:0]  base, sym_word, pk_word, wr_word;

    assign accept     = sym_valid & sym_ready;
    assign frame_done = (state == DONE);

    // Effective operands: in IDLE the frame starts fresh from the live selects.
    always_comb begin
        in_idle = (state == IDLE);
        mode_n  = in_idle ? ~cod_ce_v : mode_n_q;
        slot    = in_idle ? 3'd0 : slot_q;
        idx     = in_idle ? '0 : idx_q;
        base    = in_idle ? '0 : asm_q;
        if (mode_n)
            sym_word = RAM_W'(sym_data[N_W-1:0]) << (int'(slot) * N_W);
        else
            sym_word = RAM_W'(sym_data) << (int'(slot) * V_W);
        pk_word   = base | sym_word;
        word_full = mode_n ? (slot == 3'(N_SLOTS - 1)) : (slot == 3'(V_SLOTS - 1));
    end

    // Word as written to RAM; v-mode spare bits optionally carry mark/parity.
    always_comb begin
        wr_word = pk_word;
`ifdef MUX_PACK_MARK_EN
        if (!mode_n) begin
            wr_word[31] = sym_last;
            wr_word[30] = ^pk_word[29:0];
        end
`endif
    end

    // Next-state and handshake.
    always_comb begin
        state_nxt = state;
        sym_ready = 1'b0;
        case (state)
            IDLE: begin
                sym_ready = nrst & (cod_ce_v | cod_ce_n);
                if (sym_valid && sym_ready)
                    state_nxt = sym_last ? LAST : PACK;
            end
            PACK: begin
                sym_ready = 1'b1;
                // once the RAM is full a final symbol skips the write cycle
                if (sym_valid && sym_last)
                    state_nxt = full_q ? DONE : LAST;
            end
            LAST:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_15_o or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Assembly, write port, overflow and frame reporting.
    always_ff @(posedge clk_15_o or negedge nrst) begin
        if (!nrst) begin
            mode_n_q    <= 1'b0;
            full_q      <= 1'b0;
            slot_q      <= '0;
            idx_q       <= '0;
            asm_q       <= '0;
            ram_tx_we   <= 1'b0;
            ram_tx_addr <= '0;
            ram_tx_data <= '0;
            weight_pack <= '0;
            ovf         <= 1'b0;
        end else begin
            ram_tx_we <= 1'b0;
            if (state == LAST)
                weight_pack <= ram_tx_addr;
            if (accept) begin
                if (in_idle) begin
                    mode_n_q <= ~cod_ce_v;
                    ovf      <= 1'b0;
                    full_q   <= 1'b0;
                end
                if (full_q && !in_idle) begin
                    // past the end of RAM: drop the symbol
                    ovf <= 1'b1;
                    if (sym_last)
                        weight_pack <= '1;
                end else if (sym_last || word_full) begin
                    ram_tx_we   <= 1'b1;
                    ram_tx_addr <= idx;
                    ram_tx_data <= wr_word;
                    asm_q       <= '0;
                    slot_q      <= '0;
                    idx_q       <= idx;
                    if (!sym_last) begin
                        // hold the index at the top instead of wrapping
                        if (&idx) full_q <= 1'b1;
                        else      idx_q  <= idx + ADDR_W'(1);
                    end
                end else begin
                    asm_q  <= pk_word;
                    slot_q <= slot + 3'd1;
                    idx_q  <= idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_v_n_pack.sv
// Bench for mux_v_n_pack: directed test-plan frames plus randomized frames,
// checked every cycle against a symbol-position model of the packer.
module tb_mux_v_n_pack;
    localparam int AW = 2;
`ifdef MUX_PACK_MARK_EN
    localparam bit MARK = 1'b1;
`else
    localparam bit MARK = 1'b0;
`endif

    logic          clk = 1'b0, nrst = 1'b0;
    logic          ce_v = 1'b0, ce_n = 1'b0, valid = 1'b0, last = 1'b0;
    logic [5:0]    data = '0;
    logic          ready, we, fd, ovf;
    logic [AW-1:0] addr, wp;
    logic [31:0]   wdata;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    mux_v_n_pack #(.RAM_W(32), .ADDR_W(AW), .V_W(6), .N_W(4)) dut (
        .clk_15_o(clk), .nrst(nrst), .cod_ce_v(ce_v), .cod_ce_n(ce_n),
        .sym_valid(valid), .sym_data(data), .sym_last(last), .sym_ready(ready),
        .ram_tx_we(we), .ram_tx_addr(addr), .ram_tx_data(wdata),
        .weight_pack(wp), .frame_done(fd), .ovf(ovf)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mark(input logic [31:0] d, input logic fin, input logic n);
        logic [31:0] r;
        r = d;
        if (MARK && !n) begin
            r[30] = ($countones(d[29:0]) % 2) == 1;
            r[31] = fin;
        end
        return r;
    endfunction

    // ---------------- reference model ----------------
    // ph: 0 idle, 1 packing, 2 final write pending, 3 done
    int            ph = 0, cnt = 0, per, wid, p, w, s;
    logic          m_n = 1'b0, e_rdy, acc;
    logic [31:0]   wbuf [4];
    logic          e_we = 1'b0, e_ovf = 1'b0;
    logic [AW-1:0] e_addr = '0, e_wp = '0, last_w = '0;
    logic [31:0]   e_data = '0;
    logic [5:0]    val;
    logic [AW-1:0] wr_a [$];
    logic [31:0]   wr_d [$];
    int            fd_cnt = 0;

    always @(negedge clk) begin
        if (!nrst) begin
            ph = 0; e_we = 1'b0; e_wp = '0; e_ovf = 1'b0;
            chk("rst_ready", ready, 0);
            chk("rst_we", we, 0);
            chk("rst_done", fd, 0);
            chk("rst_ovf", ovf, 0);
            chk("rst_wp", wp, 0);
            chk("rst_addr", addr, 0);
            chk("rst_data", wdata, 0);
        end else begin
            e_rdy = (ph == 0) ? (ce_v | ce_n) : (ph == 1);
            chk("ready", ready, e_rdy);
            chk("we", we, e_we);
            chk("frame_done", fd, ph == 3);
            chk("weight_pack", wp, e_wp);
            chk("ovf", ovf, e_ovf);
            if (e_we) begin
                chk("addr", addr, e_addr);
                chk("data", wdata, e_data);
            end
            if (we) begin wr_a.push_back(addr); wr_d.push_back(wdata); end
            if (fd) fd_cnt++;
            // advance to what the next cycle must show
            acc  = valid & e_rdy;
            e_we = 1'b0;
            case (ph)
                2: begin ph = 3; e_wp = last_w; end
                3: ph = 0;
                default: if (acc) begin
                    if (ph == 0) begin
                        m_n = !ce_v; cnt = 0; e_ovf = 1'b0;
                        for (int i = 0; i < 4; i++) wbuf[i] = '0;
                    end
                    per = m_n ? 8 : 5;
                    wid = m_n ? 4 : 6;
                    p   = cnt;
                    cnt++;
                    if (p < per * 4) begin
                        w   = p / per;
                        s   = p % per;
                        val = m_n ? {2'b00, data[3:0]} : data;
                        wbuf[w] = wbuf[w] | (32'(val) << (s * wid));
                        ph = last ? 2 : 1;
                        if (last || s == per - 1) begin
                            e_we   = 1'b1;
                            e_addr = AW'(w);
                            e_data = mark(wbuf[w], last, m_n);
                            last_w = AW'(w);
                        end
                    end else begin
                        e_ovf = 1'b1;
                        if (last) begin ph = 3; e_wp = '1; end
                        else ph = 1;
                    end
                end
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [5:0] d, input logic l);
        int   n;
        logic ok;
        n = 0;
        valid = 1'b1; data = d; last = l;
        do begin
            @(negedge clk); ok = ready;
            @(posedge clk); #1;
            n++;
        end while (!ok && n < 100);
        valid = 1'b0; last = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout: got ready=0 want ready=1 within 100 cycles");
        end
    endtask

    task automatic clr_log();
        wr_a.delete(); wr_d.delete(); fd_cnt = 0;
    endtask

    task automatic rframe(input logic v, input logic n, input int len, input bit gaps, input bit tog);
        ce_v = v; ce_n = n;
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(3) == 0) idle(1 + $urandom_range(2));
            if (tog && i == 1) begin ce_v = ~ce_v; ce_n = $urandom_range(1) == 1; end
            send(6'($urandom_range(63)), i == len - 1);
        end
        idle(3);
    endtask

    initial begin
        @(posedge clk); #1;
        idle(3);
        nrst = 1'b1;
        idle(2);

        // v-mode 1..5
        clr_log(); ce_v = 1'b1; ce_n = 1'b0;
        for (int i = 1; i <= 5; i++) send(6'(i), i == 5);
        idle(3);
        chk("v5_writes", wr_d.size(), 1);
        if (wr_d.size() >= 1) begin
            chk("v5_addr", wr_a[0], 0);
            chk("v5_data", wr_d[0], MARK ? 32'hC5103081 : 32'h05103081);
        end
        chk("v5_wp", wp, 0);
        chk("v5_done_cnt", fd_cnt, 1);

        // n-mode 1..8, upper data bits set to prove they are ignored
        clr_log(); ce_v = 1'b0; ce_n = 1'b1;
        for (int i = 1; i <= 8; i++) send(6'(i) | 6'h30, i == 8);
        idle(3);
        chk("n8_writes", wr_d.size(), 1);
        if (wr_d.size() >= 1) chk("n8_data", wr_d[0], 32'h87654321);

        // v-mode 1..7, both selects high (v wins)
        clr_log(); ce_v = 1'b1; ce_n = 1'b1;
        for (int i = 1; i <= 7; i++) send(6'(i), i == 7);
        idle(3);
        chk("v7_writes", wr_d.size(), 2);
        if (wr_d.size() >= 2) begin
            chk("v7_d0", wr_d[0], MARK ? 32'h45103081 : 32'h05103081);
            chk("v7_a1", wr_a[1], 1);
            chk("v7_d1", wr_d[1], MARK ? 32'hC00001C6 : 32'h000001C6);
        end
        chk("v7_wp", wp, 1);

        // no selects: valid is not consumed
        clr_log(); ce_v = 1'b0; ce_n = 1'b0;
        valid = 1'b1; data = 6'd9; idle(4); valid = 1'b0;
        chk("nosel_writes", wr_d.size(), 0);

        // overflow: 22 v-symbols into 4 words
        clr_log(); ce_v = 1'b1;
        for (int i = 0; i < 22; i++) send(6'(i + 1), i == 21);
        idle(3);
        chk("ovf_writes", wr_d.size(), 4);
        if (wr_a.size() >= 4) chk("ovf_last_addr", wr_a[3], 3);
        chk("ovf_flag", ovf, 1);
        chk("ovf_wp", wp, 3);
        chk("ovf_done_cnt", fd_cnt, 1);

        // reset mid-frame
        clr_log();
        for (int i = 1; i <= 3; i++) send(6'(i), 1'b0);
        #2 nrst = 1'b0;
        @(negedge clk);
        @(posedge clk); #1 nrst = 1'b1;
        idle(2);
        chk("rst_abort_writes", wr_d.size(), 0);
        chk("rst_abort_done", fd_cnt, 0);
        for (int i = 1; i <= 5; i++) send(6'(i), i == 5);
        idle(3);
        chk("rst_new_writes", wr_d.size(), 1);
        if (wr_d.size() >= 1) begin
            chk("rst_new_addr", wr_a[0], 0);
            chk("rst_new_data", wr_d[0], MARK ? 32'hC5103081 : 32'h05103081);
        end

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            logic v, n;
            v = $urandom_range(1) == 1;
            n = !v || ($urandom_range(1) == 1);
            rframe(v, n, 1 + $urandom_range(v ? 24 : 36),
                   $urandom_range(1) == 1, $urandom_range(3) == 0);
            if ($urandom_range(4) == 0) begin
                ce_v = 1'b0; ce_n = 1'b0; valid = 1'b1; idle(2); valid = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
